// File: rtl/uart_rx_deframer.sv
// Oversampling UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Bytes are held on a valid/ack register; framing, overrun and parity errors are 1-clock pulses.
module uart_rx_deframer #(
    parameter int unsigned CLOCK_SPEED = 27000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] dataOut,
    output logic       rxValid,
    input  logic       rxAck,
    output logic       frameError,
    output logic       overrun,
    output logic       parityError
);
    localparam int unsigned Div     = CLOCK_SPEED / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned SampleW = $clog2(OVERSAMPLE);
    localparam logic [SampleW-1:0] HalfLast = SampleW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampleW-1:0] BitLast  = SampleW'(OVERSAMPLE - 1);
    localparam logic [31:0]        TickLast = 32'(Div - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

    state_e             r_state;
    logic               r_sync1, r_sync2, r_rx_prev;
    logic [31:0]        r_tick_cnt;
    logic [SampleW-1:0] r_sample_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bad;
    logic               r_parity_err;
`endif

    logic w_rxs;
    logic w_tick;
    logic w_bit_end;

    assign w_rxs     = r_sync2;
    assign w_tick    = (r_tick_cnt == TickLast);
    assign w_bit_end = w_tick && (r_sample_cnt == BitLast);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_tick_cnt   <= '0;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;
            if (rxAck) begin
                r_valid <= 1'b0;
            end
            if (r_state != StIdle && r_state != StBreak && w_tick) begin
                r_sample_cnt <= r_sample_cnt + SampleW'(1);
            end

            case (r_state)
                StIdle: begin
                    // Restart the tick divider so samples land on bit centres.
                    if (r_rx_prev && !w_rxs) begin
                        r_state      <= StStart;
                        r_tick_cnt   <= '0;
                        r_sample_cnt <= '0;
                    end
                end
                StStart: begin
                    if (w_tick && r_sample_cnt == HalfLast) begin
                        r_sample_cnt <= '0;
                        r_bit_cnt    <= '0;
                        r_state      <= w_rxs ? StIdle : StData;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_sample_cnt        <= '0;
                        r_shift[r_bit_cnt]  <= w_rxs;
                        r_bit_cnt           <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= StParity;
`else
                            r_state <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (w_bit_end) begin
                        r_sample_cnt <= '0;
                        r_par_bad    <= (w_rxs != ^r_shift);
                        r_state      <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (w_bit_end) begin
                        r_sample_cnt <= '0;
                        if (!w_rxs) begin
                            r_frame_err <= 1'b1;
                            r_state     <= StBreak;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_parity_err <= 1'b1;
                            r_state      <= StIdle;
`endif
                        end else begin
                            // A same-clock ack frees the holder, so no overrun then.
                            r_data    <= r_shift;
                            r_valid   <= 1'b1;
                            r_overrun <= r_valid && !rxAck;
                            r_state   <= StIdle;
                        end
                    end
                end
                StBreak: begin
                    if (w_rxs) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign dataOut    = r_data;
    assign rxValid    = r_valid;
    assign frameError = r_frame_err;
    assign overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parityError = r_parity_err;
`else
    assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer at 32 clocks per bit (DIV=2, OVERSAMPLE=16).
module tb_uart_rx_deframer;
    localparam int unsigned BitClks = 32;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif
    // Start edge to commit edge: 2 sync + 1 detect, 8 ticks to start centre, then whole bits.
    localparam int unsigned CommitClk = 19 + BitClks * (FrameBits - 1);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rxAck = 1'b0;
    logic [7:0] dataOut;
    logic       rxValid, frameError, overrun, parityError;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef enum int {EvByte, EvOverrun, EvFrame, EvParity} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx_deframer #(
        .CLOCK_SPEED(3200000),
        .BAUD_RATE  (100000),
        .OVERSAMPLE (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .dataOut    (dataOut),
        .rxValid    (rxValid),
        .rxAck      (rxAck),
        .frameError (frameError),
        .overrun    (overrun),
        .parityError(parityError)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic take_ev(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %02h required none", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data !== d) begin
                errors++;
                $display("FAIL event: got kind %0d data %02h required kind %0d data %02h",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: a commit shows as rxValid rising or dataOut changing while valid.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_data  = dataOut;
        end else begin
            if (rxValid && (!prev_valid || dataOut !== prev_data)) take_ev(EvByte, dataOut);
            if (overrun)     take_ev(EvOverrun, 8'h00);
            if (frameError)  take_ev(EvFrame, 8'h00);
            if (parityError) take_ev(EvParity, 8'h00);
            prev_valid = rxValid;
            prev_data  = dataOut;
        end
    end

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (BitClks) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(posedge clock);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d ^ par_flip);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rxValid && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, rxValid, 1'b1);
    endtask

    task automatic ack_byte();
        @(posedge clock);
        #1 rxAck = 1'b1;
        @(posedge clock);
        #1 rxAck = 1'b0;
    endtask

    initial begin
        repeat (5) @(posedge clock);
        #2;
        check("reset_dataOut", dataOut, 8'h00);
        check("reset_rxValid", rxValid, 1'b0);
        check("reset_frameError", frameError, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_parityError", parityError, 1'b0);
        reset = 1'b0;
        repeat (10) @(posedge clock);

        // Good byte, acked a few clocks later.
        expect_ev(EvByte, 8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_valid("a5_valid");
        check("a5_data", dataOut, 8'hA5);
        repeat (3) @(posedge clock);
        ack_byte();
        check("a5_acked", rxValid, 1'b0);

        // Short low pulse is rejected at the start-bit centre.
        @(posedge clock);
        #1 uart_rx = 1'b0;
        repeat (10) @(posedge clock);
        #1 uart_rx = 1'b1;
        repeat (100) @(posedge clock);
        #1 check("glitch_valid", rxValid, 1'b0);

        // Stop bit low, line held in break, then a clean frame.
        expect_ev(EvFrame, 8'h00);
        send_frame(8'h3C, 1'b0);
        repeat (100) @(posedge clock);
        #1 uart_rx = 1'b1;
        repeat (20) @(posedge clock);
        #1 check("frame_valid", rxValid, 1'b0);
        expect_ev(EvByte, 8'h55);
        send_frame(8'h55, 1'b1);
        wait_valid("x55_valid");
        check("x55_data", dataOut, 8'h55);
        ack_byte();

        // Two frames with no ack in between.
        expect_ev(EvByte, 8'h11);
        expect_ev(EvByte, 8'h22);
        expect_ev(EvOverrun, 8'h00);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_valid", rxValid, 1'b1);
        check("ovr_data", dataOut, 8'h22);

        // Ack lands on the commit clock while 0x22 is still held.
        expect_ev(EvByte, 8'h7E);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                @(posedge clock);
                repeat (CommitClk - 1) @(posedge clock);
                #1 rxAck = 1'b1;
                @(posedge clock);
                #1 rxAck = 1'b0;
            end
        join
        check("coll_valid", rxValid, 1'b1);
        check("coll_data", dataOut, 8'h7E);

        // Reset during bit 4 of a frame whose remaining bits are all high.
        fork
            send_frame(8'hF7, 1'b1);
            begin
                @(posedge clock);
                repeat (170) @(posedge clock);
                #1 reset = 1'b1;
                #2;
                check("mreset_valid", rxValid, 1'b0);
                check("mreset_data", dataOut, 8'h00);
                check("mreset_frame", frameError, 1'b0);
                check("mreset_overrun", overrun, 1'b0);
                @(posedge clock);
                #1 reset = 1'b0;
            end
        join
        repeat (50) @(posedge clock);
        #1 check("mreset_idle_valid", rxValid, 1'b0);
        expect_ev(EvByte, 8'h81);
        send_frame(8'h81, 1'b1);
        wait_valid("x81_valid");
        check("x81_data", dataOut, 8'h81);
        ack_byte();

`ifdef UART_RX_PARITY_EN
        expect_ev(EvByte, 8'h07);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        wait_valid("par_ok_valid");
        check("par_ok_data", dataOut, 8'h07);
        ack_byte();
        expect_ev(EvParity, 8'h00);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        repeat (20) @(posedge clock);
        #1 check("par_bad_valid", rxValid, 1'b0);
`endif

        repeat (50) @(posedge clock);
        #1 check("events_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive half of the board UART. Oversamples the asynchronous `uart_rx` pin and recovers 8N1 frames (optional even parity).
- Presents each byte on a valid/ack holding register to downstream logic, e.g. a loopback into the transmitter's `dataIn`.
- Flags framing errors, overruns and (optionally) parity errors.

Parameters:
- CLOCK_SPEED, 27000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and ≥4.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- uart_rx  input  1  raw serial line; idles high; asynchronous to `clock`.
- dataOut  output  8  last good received byte; LSB received first.
- rxValid  output  1  dataOut holds an unconsumed byte.
- rxAck  input  1  consumer takes the byte; sampled on the clock edge.
- frameError  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte arrived while rxValid was still set.
- parityError  output  1  one-cycle pulse on a parity mismatch; constant 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset values: dataOut=0, rxValid=0, frameError=0, overrun=0, parityError=0. State=IDLE, all counters 0, synchronizer flops=1.
- Asserting reset mid-frame aborts the frame at once; no output pulses are produced for it.
- Synchronizer:
  - `uart_rx` passes through 2 flops; all logic uses the 2nd flop output (rxS).
  - Adds 2 clocks of latency.
- Tick generator:
  - DIV = CLOCK_SPEED/(BAUD_RATE*OVERSAMPLE), integer division, must be ≥1.
  - A 32-bit counter emits a 1-clock `tick` every DIV clocks.
  - The counter is cleared on entry to START so sampling phase aligns to the start edge.
- Sample counter: counts ticks within a bit, 0..OVERSAMPLE-1.
- Bit counter: 0..7; 3 bits are enough.
- State machine; transitions occur only on tick unless noted:
  - IDLE: on rxS falling edge (previous 1, current 0; checked every clock) go to START.
  - START: at tick OVERSAMPLE/2-1 (bit centre), resample rxS.
    - rxS=1: glitch; return to IDLE with no outputs.
    - rxS=0: go to DATA; reset the sample counter.
  - DATA: every OVERSAMPLE ticks, sample rxS into shift register bit [bitCnt], LSB first.
    - After bit 7, go to PARITY if the macro is defined, else to STOP.
  - PARITY (macro only): sample one bit and compare with XOR of the 8 data bits (even parity).
    - Mismatch: latch the error for the stop phase. Then go to STOP.
  - STOP: sample the stop bit at its centre.
    - rxS=1 and no parity error: commit. dataOut<=shift register; rxValid<=1 on the next clock. Go to IDLE.
    - rxS=1 with parity error: parityError pulse; byte discarded; go to IDLE.
    - rxS=0: frameError pulse; byte discarded; go to BREAK.
  - BREAK: wait until rxS=1 (checked every clock), then go to IDLE. This prevents false starts during a line break.
- Latency: rxValid rises 1 clock after the stop-bit centre tick. This is about 9.5 bit times after the start edge, plus 2 sync clocks.
- Handshake:
  - rxValid stays high until a clock edge with rxAck=1, then clears.
  - rxAck while rxValid=0 is ignored.
  - A commit with rxValid=1 and rxAck=0: dataOut is overwritten, rxValid stays 1, and an overrun pulse is raised.
  - A commit in the same clock as rxAck=1: dataOut takes the new byte, rxValid stays 1, no overrun.
- Back-to-back frames: a new start edge is accepted in the clock after STOP returns to IDLE. There is no minimum idle gap.
- Error pulses are exactly 1 clock wide and mutually exclusive per frame.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Frame is 8E1; the PARITY state is compiled in.
  - parityError is driven as described above.
  - Frame length is 11 bits.
- Not defined:
  - Frame is 8N1; no PARITY state.
  - parityError is tied to 0.

Test Plan:
- Good byte: sim params CLOCK_SPEED=3200000, BAUD_RATE=100000, OVERSAMPLE=16 (DIV=2, 32 clocks/bit). Send 0xA5 8N1 -> rxValid=1, dataOut=0xA5. Assert rxAck 3 clocks later -> rxValid=0. No error pulses.
- Glitch rejection: drive uart_rx low for 10 clocks, then high -> state returns to IDLE; rxValid, frameError and overrun all stay 0.
- Framing: send 0x3C with stop bit=0, hold line low 100 clocks, then release -> one frameError pulse; rxValid stays 0. Next frame 0x55 is received correctly.
- Overrun: send 0x11 then 0x22 back-to-back with no rxAck -> one overrun pulse at the second commit; dataOut=0x22; rxValid=1.
- Ack collision plus mid-frame reset:
  - Ack collision: rxAck=1 in the commit clock of 0x7E -> rxValid=1, dataOut=0x7E, no overrun.
  - Mid-frame reset: assert reset during bit 4 of the next frame -> all outputs 0 immediately; the following frame 0x81 is received cleanly.
- Parity (UART_RX_PARITY_EN): send 0x07 with parity bit 1 -> accepted. Send 0x07 with parity bit 0 -> one parityError pulse; rxValid stays 0.
